watch_time_counter: RTL and testbench
=====================================

// Module: watch_time_counter
//
// PURPOSE
// BCD hours:minutes:seconds timekeeping core of the digital watch.
// Advances one second per tick pulse from the upstream 1 Hz prescaler.
// Feeds the downstream display decode/compare logic built from gate
// primitives. Provides a set mode in which individual fields are
// incremented by a push button.
//
// PARAMETERS
// HOUR_24   1   1: hours 00..23; 0: hours 01..12 with pm flag
//
// PORTS
// clk        in   1  system clock, all state updates on rising edge
// rst_n      in   1  synchronous reset, active-low
// tick       in   1  one-cycle enable pulse, once per second
// set_mode   in   1  1 = SET state requested, 0 = RUN requested
// set_sel    in   2  field to edit: 00 sec, 01 min, 10 hour, 11 none
// set_inc    in   1  one-cycle pulse: increment selected field
// sec_ones   out  4  BCD seconds units, 0..9
// sec_tens   out  4  BCD seconds tens, 0..5
// min_ones   out  4  BCD minutes units, 0..9
// min_tens   out  4  BCD minutes tens, 0..5
// hour_ones  out  4  BCD hours units
// hour_tens  out  4  BCD hours tens, 0..2
// pm         out  1  pm flag (12h mode only; tied 0 when HOUR_24=1)
// day_pulse  out  1  one-cycle pulse on midnight rollover
// setting    out  1  1 while FSM is in SET
//
// BEHAVIOUR
// - All outputs registered; update one clk edge after qualifying input.
// - Reset (rst_n=0 at edge): FSM=RUN, setting=0, day_pulse=0, pm=0.
//   Time = 00:00:00 (HOUR_24=1) or 12:00:00 am (HOUR_24=0).
// - Reset overrides everything, including mid-set and coincident tick.
// - FSM states: RUN, SET. RUN->SET when set_mode=1; SET->RUN when set_mode=0.
//   On the RUN->SET edge, seconds cleared to 00; min/hour retained.
// - RUN: each tick=1 advances time by one second, full carry chain:
//   sec 59->00 carries min; min 59->00 carries hour.
//   24h: hour 23->00. 12h: hour 12->01; 11->12 toggles pm.
//   set_inc ignored in RUN.
// - SET: tick ignored (time frozen). set_inc increments only the
//   selected field, wrapping without carry:
//   sec 59->00, min 59->00;
//   hour 23->00 (24h) or 12->01 (12h, pm toggles on 11->12).
//   set_sel=11: set_inc has no effect.
// - set_mode and set_inc in same cycle as RUN->SET transition:
//   transition only; set_inc dropped.
// - day_pulse=1 for exactly the cycle after the tick producing
//   00:00:00 (24h) or 12:00:00 am (12h). Never asserted from SET edits.
// - BCD digits never hold illegal values (>9, or tens beyond range).
//
// TESTING
// 1. rst_n=0 one edge -> all digits 0, setting=0, day_pulse=0
//    (12h: 12:00:00 am).
// 2. From 00:00:58, two ticks -> 00:00:59 then 00:01:00; no day_pulse.
// 3. Preload 23:59:59 (24h), one tick -> 00:00:00, day_pulse high
//    exactly one cycle.
// 4. 12h at 11:59:59 am, tick -> 12:00:00 pm;
//    at 12:59:59 pm, tick -> 01:00:00 pm.
// 5. set_mode=1 at 10:20:37 -> 10:20:00, setting=1; 40 ticks -> unchanged;
//    set_sel=01, 45 set_inc -> 10:05:00 (no hour carry).
// 6. SET mode with set_sel=10, rst_n=0 mid-edit -> RUN, reset time,
//    setting=0.

Source files
------------

// File: rtl/watch_time_counter.sv
// BCD hh:mm:ss timekeeping core for the watch, with a RUN/SET mode FSM.
// HOUR_24 selects 00..23 hours or 01..12 hours with a pm flag.
module watch_time_counter #(
  parameter bit HOUR_24 = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_set_mode,
  input  logic [1:0] i_set_sel,
  input  logic       i_set_inc,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_hour_ones,
  output logic [3:0] o_hour_tens,
  output logic       o_pm,
  output logic       o_day_pulse,
  output logic       o_setting
);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  localparam logic [1:0] SEL_SEC  = 2'b00;
  localparam logic [1:0] SEL_MIN  = 2'b01;
  localparam logic [1:0] SEL_HOUR = 2'b10;

  localparam logic [3:0] HOUR_RST_TENS = HOUR_24 ? 4'd0 : 4'd1;
  localparam logic [3:0] HOUR_RST_ONES = HOUR_24 ? 4'd0 : 4'd2;

  state_t     r_state;
  state_t     w_nextState;

  logic [3:0] r_secOnes, r_secTens, r_minOnes, r_minTens, r_hourOnes, r_hourTens;
  logic       r_pm;
  logic       r_dayPulse;

  logic [3:0] w_secOnes, w_secTens, w_minOnes, w_minTens, w_hourOnes, w_hourTens;
  logic       w_pm;
  logic       w_dayPulse;
  logic       w_secWrap, w_minWrap, w_hourWrap;

  // Returns {wrap, tens, ones}; >= compares keep the digits inside 00..59.
  function automatic logic [8:0] incMod60(input logic [3:0] ones, input logic [3:0] tens);
    logic [8:0] res;
    if (ones >= 4'd9) begin
      if (tens >= 4'd5) res = {1'b1, 4'd0, 4'd0};
      else              res = {1'b0, tens + 4'd1, 4'd0};
    end else begin
      res = {1'b0, tens, ones + 4'd1};
    end
    return res;
  endfunction

  // Returns {dayWrap, pm, tens, ones}; in 12h mode midnight is 11 pm -> 12 am.
  function automatic logic [9:0] incHour(input logic [3:0] ones, input logic [3:0] tens,
                                         input logic pm);
    logic [9:0] res;
    res = {1'b0, pm, tens, ones + 4'd1};
    if (HOUR_24) begin
      if (tens >= 4'd2 && ones >= 4'd3) res = {1'b1, 1'b0, 4'd0, 4'd0};
      else if (ones >= 4'd9)            res = {1'b0, 1'b0, tens + 4'd1, 4'd0};
    end else begin
      if (tens >= 4'd1 && ones >= 4'd2)      res = {1'b0, pm, 4'd0, 4'd1};
      else if (tens >= 4'd1 && ones == 4'd1) res = {pm, ~pm, 4'd1, 4'd2};
      else if (ones >= 4'd9)                 res = {1'b0, pm, 4'd1, 4'd0};
    end
    return res;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_RUN;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_RUN:  if (i_set_mode)  w_nextState = ST_SET;
      ST_SET:  if (!i_set_mode) w_nextState = ST_RUN;
      default: w_nextState = ST_RUN;
    endcase
  end

  // Entering SET wins over a coincident tick or set_inc: only seconds clear.
  always_comb begin
    w_secOnes  = r_secOnes;
    w_secTens  = r_secTens;
    w_minOnes  = r_minOnes;
    w_minTens  = r_minTens;
    w_hourOnes = r_hourOnes;
    w_hourTens = r_hourTens;
    w_pm       = r_pm;
    w_dayPulse = 1'b0;
    w_secWrap  = 1'b0;
    w_minWrap  = 1'b0;
    w_hourWrap = 1'b0;
    if (r_state == ST_RUN) begin
      if (i_set_mode) begin
        w_secOnes = 4'd0;
        w_secTens = 4'd0;
      end else if (i_tick) begin
        {w_secWrap, w_secTens, w_secOnes} = incMod60(r_secOnes, r_secTens);
        if (w_secWrap) begin
          {w_minWrap, w_minTens, w_minOnes} = incMod60(r_minOnes, r_minTens);
          if (w_minWrap) begin
            {w_hourWrap, w_pm, w_hourTens, w_hourOnes} = incHour(r_hourOnes, r_hourTens, r_pm);
            w_dayPulse = w_hourWrap;
          end
        end
      end
    end else if (i_set_inc) begin
      case (i_set_sel)
        SEL_SEC:  {w_secWrap, w_secTens, w_secOnes} = incMod60(r_secOnes, r_secTens);
        SEL_MIN:  {w_minWrap, w_minTens, w_minOnes} = incMod60(r_minOnes, r_minTens);
        SEL_HOUR: {w_hourWrap, w_pm, w_hourTens, w_hourOnes} =
                    incHour(r_hourOnes, r_hourTens, r_pm);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_secOnes  <= 4'd0;
      r_secTens  <= 4'd0;
      r_minOnes  <= 4'd0;
      r_minTens  <= 4'd0;
      r_hourOnes <= HOUR_RST_ONES;
      r_hourTens <= HOUR_RST_TENS;
      r_pm       <= 1'b0;
      r_dayPulse <= 1'b0;
    end else begin
      r_secOnes  <= w_secOnes;
      r_secTens  <= w_secTens;
      r_minOnes  <= w_minOnes;
      r_minTens  <= w_minTens;
      r_hourOnes <= w_hourOnes;
      r_hourTens <= w_hourTens;
      r_pm       <= w_pm;
      r_dayPulse <= w_dayPulse;
    end
  end

  assign o_sec_ones  = r_secOnes;
  assign o_sec_tens  = r_secTens;
  assign o_min_ones  = r_minOnes;
  assign o_min_tens  = r_minTens;
  assign o_hour_ones = r_hourOnes;
  assign o_hour_tens = r_hourTens;
  assign o_pm        = HOUR_24 ? 1'b0 : r_pm;
  assign o_day_pulse = r_dayPulse;
  assign o_setting   = (r_state == ST_SET);

endmodule

// File: tb/tb_watch_time_counter.sv
// Scoreboard bench for watch_time_counter: one 24h and one 12h instance share stimulus;
// the reference keeps time as seconds-of-day and derives both displays from it.
module tb_watch_time_counter;

  logic       clk = 1'b0;
  logic       rstN;
  logic       tick;
  logic       setMode;
  logic [1:0] setSel;
  logic       setInc;

  wire [23:0] time24;
  wire [23:0] time12;
  wire        pm24, pm12, day24, day12, setting24, setting12;

  typedef struct {
    int t;
    bit setting;
    bit day;
  } exp_t;

  exp_t expQ[$];
  int   modelT   = 0;
  bit   modelSet = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  logic mode     = 1'b0;

  always #5 clk = ~clk;

  watch_time_counter #(.HOUR_24(1'b1)) dut24 (
    .i_clk(clk), .i_rst_n(rstN), .i_tick(tick), .i_set_mode(setMode),
    .i_set_sel(setSel), .i_set_inc(setInc),
    .o_sec_ones(time24[3:0]), .o_sec_tens(time24[7:4]),
    .o_min_ones(time24[11:8]), .o_min_tens(time24[15:12]),
    .o_hour_ones(time24[19:16]), .o_hour_tens(time24[23:20]),
    .o_pm(pm24), .o_day_pulse(day24), .o_setting(setting24)
  );

  watch_time_counter #(.HOUR_24(1'b0)) dut12 (
    .i_clk(clk), .i_rst_n(rstN), .i_tick(tick), .i_set_mode(setMode),
    .i_set_sel(setSel), .i_set_inc(setInc),
    .o_sec_ones(time12[3:0]), .o_sec_tens(time12[7:4]),
    .o_min_ones(time12[11:8]), .o_min_tens(time12[15:12]),
    .o_hour_ones(time12[19:16]), .o_hour_tens(time12[23:20]),
    .o_pm(pm12), .o_day_pulse(day12), .o_setting(setting12)
  );

  function automatic logic [23:0] bcd6(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic compareVal(input string name, input logic [31:0] actual,
                            input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, required);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    int h, m, s, h12;
    h   = e.t / 3600;
    m   = (e.t / 60) % 60;
    s   = e.t % 60;
    h12 = (h % 12 == 0) ? 12 : h % 12;
    compareVal("time24", {8'd0, time24}, {8'd0, bcd6(h, m, s)});
    compareVal("time12", {8'd0, time12}, {8'd0, bcd6(h12, m, s)});
    compareVal("pm12", {31'd0, pm12}, {31'd0, (h >= 12)});
    compareVal("pm24", {31'd0, pm24}, 32'd0);
    compareVal("day24", {31'd0, day24}, {31'd0, e.day});
    compareVal("day12", {31'd0, day12}, {31'd0, e.day});
    compareVal("setting24", {31'd0, setting24}, {31'd0, e.setting});
    compareVal("setting12", {31'd0, setting12}, {31'd0, e.setting});
  endtask

  // SET edits move one field with no carry; hour wrap in h24 terms matches 12h pm rules.
  task automatic bumpField(input logic [1:0] sel);
    int h, m, s;
    h = modelT / 3600;
    m = (modelT / 60) % 60;
    s = modelT % 60;
    case (sel)
      2'b00:   s = (s + 1) % 60;
      2'b01:   m = (m + 1) % 60;
      2'b10:   h = (h + 1) % 24;
      default: ;
    endcase
    modelT = h * 3600 + m * 60 + s;
  endtask

  task automatic applyStimulus(input logic rstIn, input logic modeIn, input logic [1:0] selIn,
                               input logic incIn, input logic tickIn);
    exp_t e;
    @(negedge clk);
    rstN    = rstIn;
    setMode = modeIn;
    setSel  = selIn;
    setInc  = incIn;
    tick    = tickIn;
    e.day   = 1'b0;
    if (!rstIn) begin
      modelT   = 0;
      modelSet = 1'b0;
    end else if (!modelSet) begin
      if (modeIn) begin
        modelSet = 1'b1;
        modelT   = modelT - (modelT % 60);
      end else if (tickIn) begin
        modelT = (modelT + 1) % 86400;
        e.day  = (modelT == 0);
      end
    end else begin
      if (incIn) bumpField(selIn);
      if (!modeIn) modelSet = 1'b0;
    end
    e.t       = modelT;
    e.setting = modelSet;
    expQ.push_back(e);
  endtask

  task automatic setTime(input int h, input int m, input int s);
    int curH, curM, curS;
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    curH = modelT / 3600;
    curM = (modelT / 60) % 60;
    curS = modelT % 60;
    repeat ((h - curH + 24) % 24) applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
    repeat ((m - curM + 60) % 60) applyStimulus(1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
    repeat ((s - curS + 60) % 60) applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    rstN    = 1'b0;
    tick    = 1'b0;
    setMode = 1'b0;
    setSel  = 2'b11;
    setInc  = 1'b0;

    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);

    setTime(0, 0, 58);
    repeat (2) applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);

    setTime(23, 59, 59);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);

    setTime(11, 59, 59);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b1);
    setTime(12, 59, 59);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b1);

    // Hour edit across midnight must not raise day_pulse.
    setTime(23, 59, 59);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);

    setTime(10, 20, 37);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
    repeat (40) applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    repeat (45) applyStimulus(1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);

    for (int blk = 0; blk < 40; blk++) begin
      setTime($urandom_range(0, 23), ($urandom_range(0, 1) == 1) ? 59 : $urandom_range(0, 58),
              $urandom_range(50, 59));
      mode = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 11) == 0) mode = ~mode;
        applyStimulus(($urandom_range(0, 59) != 0), mode, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end
    end

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
